// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants and the IF/ID register layout.
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.instr    <= NOP_INSTR;
            q.valid    <= 1'b0;
        end else if (bubble) begin
            // PC fields keep their last value; only the instruction is killed
            q.instr    <= NOP_INSTR;
            q.valid    <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end
endmodule

// File: rtl/if_stage.sv
// RV32 fetch stage: PC register, next-PC mux, stall counter and IF/ID register.
module if_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [4:0]      if_id_rs1_addr,
    output logic [4:0]      if_id_rs2_addr,
    output logic [31:0]     perf_stall_cycles
);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            hold;
    logic            bubble;
    if_id_t          d;
    if_id_t          q;

    assign pc_plus4 = pc + XLEN'(4);
    assign hold     = stall && !flush;
    // Not-ready only bubbles when no stall is pending, so a stall keeps the held instruction
    assign bubble   = flush || (!stall && !imem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (flush)
            pc <= redirect_pc & ~XLEN'(3);
        else if (!stall && imem_ready)
            pc <= pc_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cycles <= '0;
        else if (hold)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end

    assign d.pc       = pc;
    assign d.pc_plus4 = pc_plus4;
    assign d.instr    = imem_rdata;
    assign d.valid    = 1'b1;

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold),
        .bubble (bubble),
        .d      (d),
        .q      (q)
    );

    assign imem_req       = !rst;
    assign imem_addr      = pc;
    assign if_id_pc       = q.pc;
    assign if_id_pc_plus4 = q.pc_plus4;
    assign if_id_instr    = q.instr;
    assign if_id_valid    = q.valid;
    assign if_id_rs1_addr = q.instr[RS1_MSB:RS1_LSB];
    assign if_id_rs2_addr = q.instr[RS2_MSB:RS2_LSB];
endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage plus a mid-stream async reset sequence.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [4:0]  if_id_rs1_addr;
    logic [4:0]  if_id_rs2_addr;
    logic [31:0] perf_stall_cycles;

    int n_vec = 0;
    int n_bad = 0;

    if_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_ready        (imem_ready),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instr       (if_id_instr),
        .if_id_valid       (if_id_valid),
        .if_id_rs1_addr    (if_id_rs1_addr),
        .if_id_rs2_addr    (if_id_rs2_addr),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] redirect;
        logic        ready;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [31:0] e_addr;
        logic [31:0] e_perf;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        check({tag, " if_id_pc"}, if_id_pc, v.e_pc);
        check({tag, " pc_plus4"}, if_id_pc_plus4, v.e_p4);
        check({tag, " instr"}, if_id_instr, v.e_instr);
        check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, v.e_valid});
        check({tag, " rs1"}, {27'd0, if_id_rs1_addr}, {27'd0, v.e_rs1});
        check({tag, " rs2"}, {27'd0, if_id_rs2_addr}, {27'd0, v.e_rs2});
        check({tag, " imem_addr"}, imem_addr, v.e_addr);
        check({tag, " perf"}, perf_stall_cycles, v.e_perf);
        check({tag, " imem_req"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        //        stall flush redirect      ready rdata          pc            p4            instr          v  rs1 rs2 addr          perf
        tbl[0]  = '{0, 0, 32'h0,          1, 32'h00500293, 32'h0,        32'h4,        32'h00500293, 1, 0,  5,  32'h8-32'h4,  0};
        tbl[1]  = '{0, 0, 32'h0,          1, 32'h005302B3, 32'h4,        32'h8,        32'h005302B3, 1, 6,  5,  32'h8,        0};
        tbl[2]  = '{1, 0, 32'h0,          1, 32'hDEADBEEF, 32'h4,        32'h8,        32'h005302B3, 1, 6,  5,  32'h8,        1};
        tbl[3]  = '{1, 1, 32'h103,        1, 32'hDEADBEEF, 32'h4,        32'h8,        32'h00000013, 0, 0,  0,  32'h100,      1};
        tbl[4]  = '{0, 0, 32'h0,          1, 32'h00000093, 32'h100,      32'h104,      32'h00000093, 1, 0,  0,  32'h104,      1};
        tbl[5]  = '{0, 1, 32'h20,         1, 32'hDEADBEEF, 32'h100,      32'h104,      32'h00000013, 0, 0,  0,  32'h20,       1};
        tbl[6]  = '{0, 0, 32'h0,          0, 32'hDEADBEEF, 32'h100,      32'h104,      32'h00000013, 0, 0,  0,  32'h20,       1};
        tbl[7]  = '{0, 0, 32'h0,          0, 32'hDEADBEEF, 32'h100,      32'h104,      32'h00000013, 0, 0,  0,  32'h20,       1};
        tbl[8]  = '{0, 0, 32'h0,          1, 32'h00A00513, 32'h20,       32'h24,       32'h00A00513, 1, 0,  10, 32'h24,       1};
        tbl[9]  = '{1, 0, 32'h0,          0, 32'hDEADBEEF, 32'h20,       32'h24,       32'h00A00513, 1, 0,  10, 32'h24,       2};
        tbl[10] = '{1, 0, 32'h0,          1, 32'hDEADBEEF, 32'h20,       32'h24,       32'h00A00513, 1, 0,  10, 32'h24,       3};
        tbl[11] = '{0, 1, 32'hFFFFFFFE,   1, 32'hDEADBEEF, 32'h20,       32'h24,       32'h00000013, 0, 0,  0,  32'hFFFFFFFC, 3};
        tbl[12] = '{0, 0, 32'h0,          1, 32'h00C58633, 32'hFFFFFFFC, 32'h0,        32'h00C58633, 1, 11, 12, 32'h0,        3};
        tbl[13] = '{0, 0, 32'h0,          1, 32'h00000013, 32'h0,        32'h4,        32'h00000013, 1, 0,  0,  32'h4,        3};

        rst = 1'b1; stall = 0; flush = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0;
        #1;
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset imem_addr", imem_addr, 32'h0);
        check("reset instr", if_id_instr, 32'h00000013);
        check("reset valid", {31'd0, if_id_valid}, 32'd0);
        check("reset perf", perf_stall_cycles, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            stall       = tbl[i].stall;
            flush       = tbl[i].flush;
            redirect_pc = tbl[i].redirect;
            imem_ready  = tbl[i].ready;
            imem_rdata  = tbl[i].rdata;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Mid-stream async reset with no clock edge between assert and check
        stall = 1; flush = 1; redirect_pc = 32'h40; imem_ready = 1;
        #1;
        rst = 1'b1;
        #1;
        check("midrst imem_req", {31'd0, imem_req}, 32'd0);
        check("midrst imem_addr", imem_addr, 32'h0);
        check("midrst if_id_pc", if_id_pc, 32'h0);
        check("midrst pc_plus4", if_id_pc_plus4, 32'h0);
        check("midrst instr", if_id_instr, 32'h00000013);
        check("midrst valid", {31'd0, if_id_valid}, 32'd0);
        check("midrst perf", perf_stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 0; flush = 0; imem_ready = 1; imem_rdata = 32'h00500293;
        @(posedge clk);
        #1;
        check_state("postrst", '{0, 0, 32'h0, 1, 32'h00500293, 32'h0, 32'h4, 32'h00500293, 1, 0, 5, 32'h4, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
